// File: rtl/iq_demod_pkg.sv
// Shared constants for the IQ CORDIC demodulator: FSM states, arctangent table
// (scaled for a 16-bit phase word) and the half-turn phase constant.
package iq_demod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREROT,
    ST_ITER,
    ST_OUT
  } demod_state_t;

  localparam int TBL_PHASE_WIDTH = 16;

  // round(atan(2^-i) * 2^16 / 2pi), i = 0..15
  localparam logic [15:0] ATAN_TBL [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  localparam logic [15:0] PI_PHASE = 16'h8000;

endpackage

// File: rtl/cordic_vec_core.sv
// Iterative vectoring CORDIC: quadrant pre-rotation on start, then ITER
// micro-rotations driving y to zero; x ends as gain*magnitude, z as the phase.
module cordic_vec_core
  import iq_demod_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int PHASE_WIDTH = 16,
  parameter int ITER        = 12
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   start,
  input  logic [IN_WIDTH-1:0]    i_in,
  input  logic [IN_WIDTH-1:0]    q_in,
  output logic                   done,
  output logic [IN_WIDTH+1:0]    x_out,
  output logic [PHASE_WIDTH-1:0] z_out
);

  localparam int XW = IN_WIDTH + 2;
  localparam int CW = $clog2(ITER + 1);
  // +pi and -pi share one bit pattern modulo 2^PHASE_WIDTH
  localparam logic [PHASE_WIDTH-1:0] Z_PI = PHASE_WIDTH'(PI_PHASE >> (TBL_PHASE_WIDTH - PHASE_WIDTH));

  logic signed [XW-1:0]    x_reg, y_reg;
  logic [PHASE_WIDTH-1:0]  z_reg;
  logic [CW-1:0]           cnt_reg;
  logic                    busy_reg;
  logic                    zero_reg;
  logic [PHASE_WIDTH-1:0]  atan_lut [2**CW];

  logic signed [XW-1:0] i_ext, q_ext, x_sh, y_sh;

  generate
    for (genvar gi = 0; gi < 2**CW; gi++) begin : g_atan
      if (gi < ITER && gi < 16) begin : g_used
        assign atan_lut[gi] = PHASE_WIDTH'(ATAN_TBL[gi] >> (TBL_PHASE_WIDTH - PHASE_WIDTH));
      end else begin : g_pad
        assign atan_lut[gi] = '0;
      end
    end
  endgenerate

  assign i_ext = {{2{i_in[IN_WIDTH-1]}}, i_in};
  assign q_ext = {{2{q_in[IN_WIDTH-1]}}, q_in};
  assign x_sh  = x_reg >>> cnt_reg;
  assign y_sh  = y_reg >>> cnt_reg;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      busy_reg <= 1'b0;
      zero_reg <= 1'b0;
      cnt_reg  <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
      // A null vector has no angle; freezing z keeps the reported phase at 0
      zero_reg <= (i_in == '0) && (q_in == '0);
      if (i_in[IN_WIDTH-1]) begin
        x_reg <= -i_ext;
        y_reg <= -q_ext;
        z_reg <= Z_PI;
      end else begin
        x_reg <= i_ext;
        y_reg <= q_ext;
        z_reg <= '0;
      end
    end else if (busy_reg) begin
      if (y_reg[XW-1]) begin
        x_reg <= x_reg - y_sh;
        y_reg <= y_reg + x_sh;
        if (!zero_reg) z_reg <= z_reg - atan_lut[cnt_reg];
      end else begin
        x_reg <= x_reg + y_sh;
        y_reg <= y_reg - x_sh;
        if (!zero_reg) z_reg <= z_reg + atan_lut[cnt_reg];
      end
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == CW'(ITER - 1)) busy_reg <= 1'b0;
    end
  end

  assign done  = busy_reg && (cnt_reg == CW'(ITER - 1));
  assign x_out = x_reg;
  assign z_out = z_reg;

endmodule

// File: rtl/iq_cordic_demod.sv
// AM/FM demodulator over a vectoring CORDIC: handshake, FSM, mode mux and phase
// differencing. Define FM_DEEMPH_EN to add a one-pole de-emphasis IIR on FM output.
module iq_cordic_demod
  import iq_demod_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 12,
  parameter int PHASE_WIDTH = 16,
  parameter int ITER        = 12
`ifdef FM_DEEMPH_EN
  ,
  parameter int DEEMPH_SHIFT = 4
`endif
) (
  input  logic                 clk_in,
  input  logic                 RST,
  input  logic                 iq_valid,
  output logic                 iq_ready,
  input  logic [IN_WIDTH-1:0]  I_IN,
  input  logic [IN_WIDTH-1:0]  Q_IN,
  input  logic                 mode,
  output logic [OUT_WIDTH-1:0] demod_out,
  output logic                 demod_valid,
  output logic                 overrun
);

  demod_state_t           state_reg;
  logic [IN_WIDTH-1:0]    i_reg, q_reg;
  logic                   mode_reg;
  logic [PHASE_WIDTH-1:0] prev_phase_reg;

  logic                   core_done;
  logic [IN_WIDTH+1:0]    x_out;
  logic [PHASE_WIDTH-1:0] z_out;

  logic [PHASE_WIDTH-1:0] dphi;
  logic [OUT_WIDTH-1:0]   dphi_out, am_out, fm_out;
  logic                   unused_bits;

  cordic_vec_core #(
    .IN_WIDTH   (IN_WIDTH),
    .PHASE_WIDTH(PHASE_WIDTH),
    .ITER       (ITER)
  ) u_core (
    .clk_in(clk_in),
    .RST   (RST),
    .start (state_reg == ST_PREROT),
    .i_in  (i_reg),
    .q_in  (q_reg),
    .done  (core_done),
    .x_out (x_out),
    .z_out (z_out)
  );

  assign dphi        = z_out - prev_phase_reg;
  assign dphi_out    = dphi[PHASE_WIDTH-1 -: OUT_WIDTH];
  assign am_out      = x_out[IN_WIDTH+1 -: OUT_WIDTH];
  assign unused_bits = ^{x_out, dphi};

`ifdef FM_DEEMPH_EN
  logic [OUT_WIDTH-1:0]        deemph_reg, deemph_next;
  logic signed [OUT_WIDTH:0]   deemph_diff, deemph_step;

  always_comb begin
    deemph_diff = {dphi_out[OUT_WIDTH-1], dphi_out} - {deemph_reg[OUT_WIDTH-1], deemph_reg};
    deemph_step = deemph_diff >>> DEEMPH_SHIFT;
    deemph_next = deemph_reg + deemph_step[OUT_WIDTH-1:0];
  end

  assign fm_out = deemph_next;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      deemph_reg <= '0;
    end else if (state_reg == ST_OUT && mode_reg) begin
      deemph_reg <= deemph_next;
    end
  end
`else
  assign fm_out = dphi_out;
`endif

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      iq_ready       <= 1'b1;
      demod_valid    <= 1'b0;
      demod_out      <= '0;
      overrun        <= 1'b0;
      prev_phase_reg <= '0;
      i_reg          <= '0;
      q_reg          <= '0;
      mode_reg       <= 1'b0;
    end else begin
      demod_valid <= 1'b0;
      if (iq_valid && !iq_ready) overrun <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (iq_valid) begin
            i_reg     <= I_IN;
            q_reg     <= Q_IN;
            mode_reg  <= mode;
            iq_ready  <= 1'b0;
            state_reg <= ST_PREROT;
          end
        end
        ST_PREROT: state_reg <= ST_ITER;
        ST_ITER: begin
          if (core_done) state_reg <= ST_OUT;
        end
        ST_OUT: begin
          demod_out      <= mode_reg ? fm_out : am_out;
          demod_valid    <= 1'b1;
          prev_phase_reg <= z_out;
          iq_ready       <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/iq_cordic_demod.md
Name: iq_cordic_demod

Overview:
- Downstream consumer of the IQ backend CIC stage; accepts decimated I/Q samples in the clk_in domain.
- Runs an iterative CORDIC in vectoring mode to get magnitude and phase per sample.
- Produces one AM (magnitude) or FM (phase-difference) audio sample per accepted I/Q pair for the voice path.

Parameters:
- IN_WIDTH, 12, width of signed I_IN/Q_IN
- OUT_WIDTH, 12, width of signed demod_out
- PHASE_WIDTH, 16, phase word; 2^PHASE_WIDTH = 2π
- ITER, 12, CORDIC micro-rotations (1..PHASE_WIDTH-2)
- DEEMPH_SHIFT, 4, de-emphasis IIR coefficient shift (used only with FM_DEEMPH_EN)

Ports:
- clk_in  in  1  system clock
- RST  in  1  synchronous, active-high reset
- iq_valid  in  1  I_IN/Q_IN hold a new sample
- iq_ready  out  1  block can accept a sample (high only in IDLE)
- I_IN  in  IN_WIDTH  signed in-phase sample
- Q_IN  in  IN_WIDTH  signed quadrature sample
- mode  in  1  0 = AM, 1 = FM; sampled at accept
- demod_out  out  OUT_WIDTH  signed demodulated sample
- demod_valid  out  1  one-cycle strobe, demod_out updated
- overrun  out  1  sticky: iq_valid seen while iq_ready low

Behaviour:
- Reset (RST synchronous, active-high, clk_in): FSM to IDLE, demod_out=0, demod_valid=0, overrun=0, iq_ready=1, prev_phase=0, de-emphasis state=0. RST mid-operation aborts the sample with no output.
- Accept: iq_valid && iq_ready at a rising edge latches I_IN, Q_IN and mode.
- FSM states and transitions:
  - IDLE -> PREROT on accept.
  - PREROT takes 1 cycle, then enters ITER.
  - ITER runs i = 0..ITER-1, then enters OUT.
  - OUT takes 1 cycle, then returns to IDLE.
- Timing: demod_valid is high exactly ITER+2 cycles after the accept edge. Max throughput is 1 sample per ITER+3 cycles.
- PREROT:
  - x, y are signed IN_WIDTH+2 bits (covers CORDIC gain ≈1.6468).
  - If I<0: x=-I, y=-Q, z = (Q>=0) ? +2^(PHASE_WIDTH-1) : -2^(PHASE_WIDTH-1).
  - Else: x=I, y=Q, z=0.
  - Negating -2^(IN_WIDTH-1) is exact because of the 2-bit extension.
- ITER step i:
  - d = (y<0).
  - x ± (y>>>i), y ∓ (x>>>i), z ∓ atan_tbl[i].
  - Arithmetic shifts only; z wraps modulo 2^PHASE_WIDTH.
- OUT, AM mode: demod_out = x[IN_WIDTH+1 -: OUT_WIDTH]. The value is always ≥0; gain is uncorrected.
- OUT, FM mode: dphi = z - prev_phase (mod 2^PHASE_WIDTH, signed). demod_out = dphi[PHASE_WIDTH-1 -: OUT_WIDTH].
- prev_phase <= z on every completed sample, in either mode.
- I=Q=0 yields z=0 and magnitude 0.
- demod_out holds its value between strobes.
- overrun sets on any cycle with iq_valid && !iq_ready. Only RST clears it. The dropped sample is ignored.

Optional Feature:
- Macro FM_DEEMPH_EN.
- Defined: in FM mode, state d <= d + ((dphi_out - d) >>> DEEMPH_SHIFT), computed in OUT. demod_out = new d. AM mode bypasses the filter; d is not updated.
- Undefined: no filter state; FM output is the raw dphi slice.

Decomposition:
- Package iq_demod_pkg:
  - atan_tbl constant array, round(atan(2^-i)·2^PHASE_WIDTH/2π) for i = 0..15.
  - FSM state enum {IDLE, PREROT, ITER, OUT}.
  - PI_PHASE constant.
- One sub-module, cordic_vec_core: the PREROT/ITER datapath and iteration counter, with start/done.
- iq_cordic_demod owns the handshake, FSM, mode mux, prev_phase, overrun and de-emphasis.

Test Plan:
- Reset: assert RST 3 cycles -> demod_out=0, demod_valid=0, overrun=0, iq_ready=1. Release -> iq_ready stays 1.
- AM: mode=0, I=1000, Q=0, one accept -> demod_valid exactly 14 cycles later; demod_out in 411..412; iq_ready low for 14 cycles.
- FM quadrature step: mode=1, samples (1000,0) then (0,1000) -> second output 1024 ±1.
- FM wrap: (-1000,10) then (-1000,-10) -> second output 13 ±1 (positive). It must not be near -4083.
- Back-pressure/overrun: hold iq_valid high 40 cycles -> exactly 3 accepts (one per 15 cycles); overrun=1 and stays 1 until RST.
- Mid-op reset: assert RST 5 cycles after accept -> no demod_valid. Next sample (1000,0) in FM -> output 0, since prev_phase was cleared. With FM_DEEMPH_EN, a 1024 step converges upward at 1/16 per sample (first output 64).
